// File: rtl/res_wr_port_if.sv
// res_wr_port_if: 256-bit result word stream with valid/ready handshake
interface res_wr_port_if;
  logic [255:0] data_i;
  logic         data_valid;
  logic         data_ready;
  modport master (output data_i, data_valid, input data_ready);
  modport slave  (input data_i, data_valid, output data_ready);
endinterface

// File: rtl/res_wr_port.sv
// res_wr_port: scatters 256-bit result words round-robin into four 128-bit bank pairs
module res_wr_port #(
  parameter logic [14:0] BASE_ADDR = 15'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          res_wr_port_start,
  input  logic [17:0]   res_len,
  res_wr_port_if.slave  bus,
  output logic          bwe_0,
  output logic          bwe_1,
  output logic          bwe_2,
  output logic          bwe_3,
  output logic          bwe_4,
  output logic          bwe_5,
  output logic          bwe_6,
  output logic          bwe_7,
  output logic [14:0]   bwaddr_0,
  output logic [14:0]   bwaddr_1,
  output logic [14:0]   bwaddr_2,
  output logic [14:0]   bwaddr_3,
  output logic [14:0]   bwaddr_4,
  output logic [14:0]   bwaddr_5,
  output logic [14:0]   bwaddr_6,
  output logic [14:0]   bwaddr_7,
  output logic [127:0]  bwdata_0,
  output logic [127:0]  bwdata_1,
  output logic [127:0]  bwdata_2,
  output logic [127:0]  bwdata_3,
  output logic [127:0]  bwdata_4,
  output logic [127:0]  bwdata_5,
  output logic [127:0]  bwdata_6,
  output logic [127:0]  bwdata_7,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [17:0] cnt, len;
  logic [7:0] we;
  logic [14:0] wa [8];
  logic [127:0] wd [8];
  logic start_ok, acc, last;
  logic [14:0] addr;
  assign start_ok = (state == IDLE) && res_wr_port_start;
  assign acc = bus.data_valid && bus.data_ready;
  assign last = cnt == len - 18'd1;
  assign addr = BASE_ADDR + cnt[16:2];
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state and state-decoded outputs; a zero-length start skips straight to DONE
  always_comb begin
    state_nxt = state;
    if (start_ok) state_nxt = (res_len == 18'd0) ? DONE : RUN;
    else if (state == RUN && acc && last) state_nxt = DONE;
    else if (state == DONE) state_nxt = IDLE;
    bus.data_ready = state == RUN;
    busy = state != IDLE;
    done = state == DONE;
  end
  // word counter and latched length; length only captured on an accepted start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      len <= '0;
    end else if (start_ok) begin
      cnt <= '0;
      len <= res_len;
    end else if (acc) begin
      cnt <= cnt + 18'd1;
    end
  // one-cycle bank writes; unwritten banks keep their last address and data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we <= '0;
      for (int b = 0; b < 8; b++) begin
        wa[b] <= '0;
        wd[b] <= '0;
      end
    end else begin
      we <= acc ? 8'(8'b11 << {cnt[1:0], 1'b0}) : 8'd0;
      for (int b = 0; b < 8; b++)
        if (acc && cnt[1:0] == 2'(b / 2)) begin
          wa[b] <= addr;
          wd[b] <= (b % 2 == 1) ? bus.data_i[255:128] : bus.data_i[127:0];
        end
    end
  assign {bwe_7, bwe_6, bwe_5, bwe_4, bwe_3, bwe_2, bwe_1, bwe_0} = we;
  assign bwaddr_0 = wa[0];
  assign bwaddr_1 = wa[1];
  assign bwaddr_2 = wa[2];
  assign bwaddr_3 = wa[3];
  assign bwaddr_4 = wa[4];
  assign bwaddr_5 = wa[5];
  assign bwaddr_6 = wa[6];
  assign bwaddr_7 = wa[7];
  assign bwdata_0 = wd[0];
  assign bwdata_1 = wd[1];
  assign bwdata_2 = wd[2];
  assign bwdata_3 = wd[3];
  assign bwdata_4 = wd[4];
  assign bwdata_5 = wd[5];
  assign bwdata_6 = wd[6];
  assign bwdata_7 = wd[7];
endmodule

// File: tb/tb_res_wr_port.sv
// tb_res_wr_port: directed vector bench for res_wr_port at two base addresses
module tb_res_wr_port;
  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic [17:0] res_len = '0;
  logic [255:0] data = '0;
  logic valid = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  res_wr_port_if ifa ();
  res_wr_port_if ifb ();
  assign ifa.data_i = data;
  assign ifa.data_valid = valid;
  assign ifb.data_i = data;
  assign ifb.data_valid = valid;
  logic [7:0] bwe_a, bwe_b;
  logic [14:0] ba_a [8];
  logic [14:0] ba_b [8];
  logic [127:0] bd_a [8];
  logic [127:0] bd_b [8];
  logic busy_a, busy_b, done_a, done_b;
  res_wr_port #(.BASE_ADDR(15'd0)) dut_a (
    .clk(clk), .rst_n(rst_n), .res_wr_port_start(start), .res_len(res_len), .bus(ifa.slave),
    .bwe_0(bwe_a[0]), .bwe_1(bwe_a[1]), .bwe_2(bwe_a[2]), .bwe_3(bwe_a[3]),
    .bwe_4(bwe_a[4]), .bwe_5(bwe_a[5]), .bwe_6(bwe_a[6]), .bwe_7(bwe_a[7]),
    .bwaddr_0(ba_a[0]), .bwaddr_1(ba_a[1]), .bwaddr_2(ba_a[2]), .bwaddr_3(ba_a[3]),
    .bwaddr_4(ba_a[4]), .bwaddr_5(ba_a[5]), .bwaddr_6(ba_a[6]), .bwaddr_7(ba_a[7]),
    .bwdata_0(bd_a[0]), .bwdata_1(bd_a[1]), .bwdata_2(bd_a[2]), .bwdata_3(bd_a[3]),
    .bwdata_4(bd_a[4]), .bwdata_5(bd_a[5]), .bwdata_6(bd_a[6]), .bwdata_7(bd_a[7]),
    .busy(busy_a), .done(done_a));
  res_wr_port #(.BASE_ADDR(15'h7FFF)) dut_b (
    .clk(clk), .rst_n(rst_n), .res_wr_port_start(start), .res_len(res_len), .bus(ifb.slave),
    .bwe_0(bwe_b[0]), .bwe_1(bwe_b[1]), .bwe_2(bwe_b[2]), .bwe_3(bwe_b[3]),
    .bwe_4(bwe_b[4]), .bwe_5(bwe_b[5]), .bwe_6(bwe_b[6]), .bwe_7(bwe_b[7]),
    .bwaddr_0(ba_b[0]), .bwaddr_1(ba_b[1]), .bwaddr_2(ba_b[2]), .bwaddr_3(ba_b[3]),
    .bwaddr_4(ba_b[4]), .bwaddr_5(ba_b[5]), .bwaddr_6(ba_b[6]), .bwaddr_7(ba_b[7]),
    .bwdata_0(bd_b[0]), .bwdata_1(bd_b[1]), .bwdata_2(bd_b[2]), .bwdata_3(bd_b[3]),
    .bwdata_4(bd_b[4]), .bwdata_5(bd_b[5]), .bwdata_6(bd_b[6]), .bwdata_7(bd_b[7]),
    .busy(busy_b), .done(done_b));
  typedef struct {
    logic start;
    logic [17:0] len;
    logic valid;
    int wk_in;
    logic [7:0] ebwe;
    int wk;
    logic erdy;
    logic ebusy;
    logic edone;
  } vec_t;
  vec_t tbl [11];
  function automatic logic [255:0] word(input int k);
    return {{4{32'h1000_0000 + k}}, {4{32'h2000_0000 + k}}};
  endfunction
  function automatic logic [7:0] mask(input int k);
    return 8'(8'b11 << (2 * (k % 4)));
  endfunction
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic s, input logic [17:0] l, input logic v, input int k);
    start = s;
    res_len = l;
    valid = v;
    data = word(k);
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cyc(input logic [7:0] eb, input int k, input logic er, input logic ebz, input logic ed);
    logic [255:0] w;
    w = word(k);
    chk("bwe_a", 256'(bwe_a), 256'(eb));
    chk("bwe_b", 256'(bwe_b), 256'(eb));
    chk("ready_a", 256'(ifa.data_ready), 256'(er));
    chk("ready_b", 256'(ifb.data_ready), 256'(er));
    chk("busy_a", 256'(busy_a), 256'(ebz));
    chk("busy_b", 256'(busy_b), 256'(ebz));
    chk("done_a", 256'(done_a), 256'(ed));
    chk("done_b", 256'(done_b), 256'(ed));
    for (int b = 0; b < 8; b++)
      if (eb[b]) begin
        chk($sformatf("addr_a[%0d]", b), 256'(ba_a[b]), 256'(15'(k / 4)));
        chk($sformatf("addr_b[%0d]", b), 256'(ba_b[b]), 256'(15'(32'h7FFF + k / 4)));
        chk($sformatf("data_a[%0d]", b), 256'(bd_a[b]), 256'((b % 2 == 1) ? w[255:128] : w[127:0]));
        chk($sformatf("data_b[%0d]", b), 256'(bd_b[b]), 256'((b % 2 == 1) ? w[255:128] : w[127:0]));
      end
  endtask
  task automatic chk_zero();
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("rst_addr_a[%0d]", b), 256'(ba_a[b]), 256'(0));
      chk($sformatf("rst_addr_b[%0d]", b), 256'(ba_b[b]), 256'(0));
      chk($sformatf("rst_data_a[%0d]", b), 256'(bd_a[b]), 256'(0));
      chk($sformatf("rst_data_b[%0d]", b), 256'(bd_b[b]), 256'(0));
    end
  endtask
  initial begin
    logic [255:0] w;
    tbl[0]  = '{1'b1, 18'd8, 1'b1, 0, 8'h00, 0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 18'd8, 1'b1, 0, 8'h03, 0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 18'd8, 1'b1, 1, 8'h0C, 1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 18'd2, 1'b1, 2, 8'h30, 2, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 18'd8, 1'b1, 3, 8'hC0, 3, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 18'd8, 1'b1, 4, 8'h03, 4, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 18'd8, 1'b1, 5, 8'h0C, 5, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 18'd8, 1'b1, 6, 8'h30, 6, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 18'd8, 1'b1, 7, 8'hC0, 7, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 18'd2, 1'b1, 8, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 18'd2, 1'b1, 9, 8'h00, 0, 1'b0, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk_cyc(8'h00, 0, 1'b0, 1'b0, 1'b0);
    chk_zero();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 18'd4, 1'b1, i);
      chk_cyc(8'h00, 0, 1'b0, 1'b0, 1'b0);
    end
    chk_zero();
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].start, tbl[i].len, tbl[i].valid, tbl[i].wk_in);
      chk_cyc(tbl[i].ebwe, tbl[i].wk, tbl[i].erdy, tbl[i].ebusy, tbl[i].edone);
    end
    w = word(4);
    chk("hold_addr_a0", 256'(ba_a[0]), 256'(15'd1));
    chk("hold_data_a0", 256'(bd_a[0]), 256'(w[127:0]));
    w = word(7);
    chk("hold_addr_b7", 256'(ba_b[7]), 256'(15'd0));
    chk("hold_data_b7", 256'(bd_b[7]), 256'(w[255:128]));
    cyc(1'b1, 18'd0, 1'b1, 20);
    chk_cyc(8'h00, 0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 18'd0, 1'b1, 21);
    chk_cyc(8'h00, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 18'd5, 1'b0, 0);
    chk_cyc(8'h00, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cyc(1'b0, 18'd5, i % 3 == 0, i / 3);
      chk_cyc((i % 3 == 0 && i <= 12) ? mask(i / 3) : 8'h00, i / 3, i < 12, i <= 12, i == 12);
    end
    cyc(1'b1, 18'd8, 1'b1, 0);
    chk_cyc(8'h00, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 18'd8, 1'b1, i);
      chk_cyc(mask(i), i, 1'b1, 1'b1, 1'b0);
    end
    rst_n = 0;
    valid = 0;
    #1;
    chk_cyc(8'h00, 0, 1'b0, 1'b0, 1'b0);
    chk_zero();
    @(posedge clk);
    #1;
    rst_n = 1;
    cyc(1'b0, 18'd8, 1'b0, 0);
    chk_cyc(8'h00, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 18'd2, 1'b1, 0);
    chk_cyc(8'h00, 0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 18'd2, 1'b1, 0);
    chk_cyc(8'h03, 0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 18'd2, 1'b1, 1);
    chk_cyc(8'h0C, 1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 18'd2, 1'b1, 2);
    chk_cyc(8'h00, 0, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
